// File: rtl/cpu_pkg.sv
//==============================================================================
// Module : cpu_pkg
// Brief  : Opcodes, instruction field positions and FSM states for the cpu core.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

package cpu_pkg;

    localparam logic [4:0] NOP   = 5'b00000;
    localparam logic [4:0] HALT  = 5'b00001;
    localparam logic [4:0] LOAD  = 5'b00010;
    localparam logic [4:0] STORE = 5'b00011;
    localparam logic [4:0] SLL   = 5'b00100;
    localparam logic [4:0] SLA   = 5'b00101;
    localparam logic [4:0] SRL   = 5'b00110;
    localparam logic [4:0] SRA   = 5'b00111;
    localparam logic [4:0] ADD   = 5'b01000;
    localparam logic [4:0] ADDI  = 5'b01001;
    localparam logic [4:0] SUB   = 5'b01010;
    localparam logic [4:0] SUBI  = 5'b01011;
    localparam logic [4:0] CMP   = 5'b01100;
    localparam logic [4:0] AND   = 5'b01101;
    localparam logic [4:0] OR    = 5'b01110;
    localparam logic [4:0] XOR   = 5'b01111;
    localparam logic [4:0] LDIH  = 5'b10000;
    localparam logic [4:0] ADDC  = 5'b10001;
    localparam logic [4:0] SUBC  = 5'b10010;
    localparam logic [4:0] JUMP  = 5'b11000;
    localparam logic [4:0] JMPR  = 5'b11001;
    localparam logic [4:0] BZ    = 5'b11010;
    localparam logic [4:0] BNZ   = 5'b11011;
    localparam logic [4:0] BN    = 5'b11100;
    localparam logic [4:0] BNN   = 5'b11101;
    localparam logic [4:0] BC    = 5'b11110;
    localparam logic [4:0] BNC   = 5'b11111;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 11;
    localparam int R1_HI  = 10;
    localparam int R1_LO  = 8;
    localparam int R2_HI  = 6;
    localparam int R2_LO  = 4;
    localparam int R3_HI  = 2;
    localparam int R3_LO  = 0;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;
    localparam int V3_HI  = 3;
    localparam int V3_LO  = 0;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    // Instructions whose result lands in gr[r1] at write-back.
    function automatic logic op_writes_gr(input logic [4:0] op);
        case (op)
            LOAD, LDIH, ADD, ADDI, ADDC, SUB, SUBI, SUBC,
            AND, OR, XOR, SLL, SLA, SRL, SRA: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_alu.sv
//==============================================================================
// Module : cpu_alu
// Brief  : Combinational ALU: result plus carry/zero/negative and flag write enable.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cpu_alu
    import cpu_pkg::*;
(
    input  logic [4:0]  i_op,
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_cf,
    output logic [15:0] o_result,
    output logic        o_cf,
    output logic        o_zf,
    output logic        o_nf,
    output logic        o_flag_we
);

    logic [16:0] w_wide;

    always_comb begin
        w_wide    = 17'd0;
        o_result  = 16'h0000;
        o_cf      = 1'b0;
        o_flag_we = 1'b0;
        case (i_op)
            ADD, ADDI: begin
                w_wide    = {1'b0, i_a} + {1'b0, i_b};
                o_result  = w_wide[15:0];
                o_cf      = w_wide[16];
                o_flag_we = 1'b1;
            end
            ADDC: begin
                w_wide    = {1'b0, i_a} + {1'b0, i_b} + {16'h0000, i_cf};
                o_result  = w_wide[15:0];
                o_cf      = w_wide[16];
                o_flag_we = 1'b1;
            end
            // Bit 16 of the 17-bit difference is the borrow.
            SUB, SUBI, CMP: begin
                w_wide    = {1'b0, i_a} - {1'b0, i_b};
                o_result  = w_wide[15:0];
                o_cf      = w_wide[16];
                o_flag_we = 1'b1;
            end
            SUBC: begin
                w_wide    = {1'b0, i_a} - {1'b0, i_b} - {16'h0000, i_cf};
                o_result  = w_wide[15:0];
                o_cf      = w_wide[16];
                o_flag_we = 1'b1;
            end
            LDIH: begin
                o_result  = i_a + i_b;
                o_flag_we = 1'b1;
            end
            AND: begin
                o_result  = i_a & i_b;
                o_flag_we = 1'b1;
            end
            OR: begin
                o_result  = i_a | i_b;
                o_flag_we = 1'b1;
            end
            XOR: begin
                o_result  = i_a ^ i_b;
                o_flag_we = 1'b1;
            end
            SLL, SLA: begin
                o_result  = i_a << i_b[3:0];
                o_flag_we = 1'b1;
            end
            SRL: begin
                o_result  = i_a >> i_b[3:0];
                o_flag_we = 1'b1;
            end
            SRA: begin
                o_result  = $signed(i_a) >>> i_b[3:0];
                o_flag_we = 1'b1;
            end
            // Address and branch-target arithmetic; flags untouched.
            LOAD, STORE, JUMP, JMPR, BZ, BNZ, BN, BNN, BC, BNC: begin
                o_result  = i_a + i_b;
            end
            default: begin
                o_result  = 16'h0000;
            end
        endcase
    end

    assign o_zf = (o_result == 16'h0000);
    assign o_nf = o_result[15];

endmodule

`default_nettype wire

// File: rtl/cpu.sv
//==============================================================================
// Module : cpu
// Brief  : 16-bit 5-stage (IF/ID/EX/MEM/WB) load/store core, no interlocks.
//          Define BRANCH_FLUSH_EN to squash the three slots behind a taken branch.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cpu (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        start,
    input  logic [15:0] i_datain,
    input  logic [15:0] d_datain,
    output logic [7:0]  i_addr,
    output logic [7:0]  d_addr,
    output logic [15:0] d_dataout,
    output logic        d_we
);
    import cpu_pkg::*;

    state_t      r_state;
    logic [7:0]  r_pc;
    logic [15:0] r_id_ir, r_ex_ir, r_mem_ir, r_wb_ir;
    logic [15:0] r_reg_a, r_reg_b, r_reg_c, r_reg_c1;
    logic [15:0] r_smdr, r_smdr1;
    logic [2:0]  flag;
    logic [15:0] gr [0:7];

    logic [4:0]  w_id_op, w_ex_op, w_mem_op, w_wb_op;
    logic [15:0] w_dec_a, w_dec_b;
    logic [15:0] w_alu_result;
    logic        w_alu_cf, w_alu_zf, w_alu_nf, w_alu_flag_we;
    logic        w_taken, w_squash, w_halt_seen, w_run;
    logic        w_unused;

    assign w_id_op  = r_id_ir[OP_HI:OP_LO];
    assign w_ex_op  = r_ex_ir[OP_HI:OP_LO];
    assign w_mem_op = r_mem_ir[OP_HI:OP_LO];
    assign w_wb_op  = r_wb_ir[OP_HI:OP_LO];
    assign w_run    = enable && (r_state == EXEC);
    assign w_unused = ^r_wb_ir[7:0];

    // Fetch stays parked from the moment HALT is decoded until it retires.
    assign w_halt_seen = (w_id_op == HALT) || (w_ex_op == HALT) ||
                         (w_mem_op == HALT) || (w_wb_op == HALT);

    always_comb begin
        w_dec_a = 16'h0000;
        w_dec_b = 16'h0000;
        case (w_id_op)
            ADD, SUB, ADDC, SUBC, CMP, AND, OR, XOR: begin
                w_dec_a = gr[r_id_ir[R2_HI:R2_LO]];
                w_dec_b = gr[r_id_ir[R3_HI:R3_LO]];
            end
            ADDI, SUBI: begin
                w_dec_a = gr[r_id_ir[R1_HI:R1_LO]];
                w_dec_b = {8'h00, r_id_ir[IMM_HI:IMM_LO]};
            end
            LDIH: begin
                w_dec_a = gr[r_id_ir[R1_HI:R1_LO]];
                w_dec_b = {r_id_ir[IMM_HI:IMM_LO], 8'h00};
            end
            LOAD, STORE, SLL, SLA, SRL, SRA: begin
                w_dec_a = gr[r_id_ir[R2_HI:R2_LO]];
                w_dec_b = {12'h000, r_id_ir[V3_HI:V3_LO]};
            end
            JUMP: begin
                w_dec_b = {8'h00, r_id_ir[IMM_HI:IMM_LO]};
            end
            JMPR, BZ, BNZ, BN, BNN, BC, BNC: begin
                w_dec_a = gr[r_id_ir[R1_HI:R1_LO]];
                w_dec_b = {8'h00, r_id_ir[IMM_HI:IMM_LO]};
            end
            default: begin
                w_dec_a = 16'h0000;
            end
        endcase
    end

    always_comb begin
        case (w_mem_op)
            JUMP, JMPR: w_taken = 1'b1;
            BZ:         w_taken = flag[1];
            BNZ:        w_taken = !flag[1];
            BN:         w_taken = flag[2];
            BNN:        w_taken = !flag[2];
            BC:         w_taken = flag[0];
            BNC:        w_taken = !flag[0];
            default:    w_taken = 1'b0;
        endcase
    end

`ifdef BRANCH_FLUSH_EN
    assign w_squash = w_taken;
`else
    assign w_squash = 1'b0;
`endif

    cpu_alu u_alu (
        .i_op      (w_ex_op),
        .i_a       (r_reg_a),
        .i_b       (r_reg_b),
        .i_cf      (flag[0]),
        .o_result  (w_alu_result),
        .o_cf      (w_alu_cf),
        .o_zf      (w_alu_zf),
        .o_nf      (w_alu_nf),
        .o_flag_we (w_alu_flag_we)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else if (enable) begin
            case (r_state)
                IDLE:    if (start) r_state <= EXEC;
                EXEC:    if (w_wb_op == HALT) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc     <= 8'h00;
            r_id_ir  <= 16'h0000;
            r_ex_ir  <= 16'h0000;
            r_mem_ir <= 16'h0000;
            r_wb_ir  <= 16'h0000;
            r_reg_a  <= 16'h0000;
            r_reg_b  <= 16'h0000;
            r_reg_c  <= 16'h0000;
            r_reg_c1 <= 16'h0000;
            r_smdr   <= 16'h0000;
            r_smdr1  <= 16'h0000;
            flag     <= 3'b000;
            for (int i = 0; i < 8; i++) begin
                gr[i] <= 16'h0000;
            end
        end else if (w_run) begin
            if (w_taken) begin
                r_pc <= r_reg_c[7:0];
            end else if (!w_halt_seen) begin
                r_pc <= r_pc + 8'd1;
            end
            r_id_ir <= (w_squash || w_halt_seen) ? {NOP, 11'h000} : i_datain;

            r_ex_ir <= w_squash ? {NOP, 11'h000} : r_id_ir;
            r_reg_a <= w_dec_a;
            r_reg_b <= w_dec_b;
            if (w_id_op == STORE) begin
                r_smdr <= gr[r_id_ir[R1_HI:R1_LO]];
            end

            r_reg_c  <= w_alu_result;
            r_mem_ir <= w_squash ? {NOP, 11'h000} : r_ex_ir;
            r_smdr1  <= r_smdr;
            if (w_alu_flag_we && !w_squash) begin
                flag <= {w_alu_nf, w_alu_zf, w_alu_cf};
            end

            r_reg_c1 <= (w_mem_op == LOAD) ? d_datain : r_reg_c;
            r_wb_ir  <= r_mem_ir;

            if (op_writes_gr(w_wb_op)) begin
                gr[r_wb_ir[R1_HI:R1_LO]] <= r_reg_c1;
            end
        end
    end

    assign i_addr    = r_pc;
    assign d_addr    = r_reg_c[7:0];
    assign d_dataout = r_smdr1;
    assign d_we      = (w_mem_op == STORE);

endmodule

`default_nettype wire

// File: tb/tb_cpu.sv
//==============================================================================
// Module : tb_cpu
// Brief  : Self-checking bench for cpu: directed programs plus random ALU programs.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_cpu;
    import cpu_pkg::*;

    logic        clock = 1'b0;
    logic        reset, enable, start;
    logic [15:0] i_datain, d_datain, d_dataout;
    logic [7:0]  i_addr, d_addr;
    logic        d_we;

    logic [15:0] irom [0:255];
    logic [15:0] dram [0:255];
    logic [15:0] prog [$];
    logic [23:0] exp_q [$];
    logic [23:0] sb_e;
    int          n_checks = 0;
    int          n_fail   = 0;

    logic [15:0] m_gr [0:7];
    logic        m_cf, m_zf, m_nf;

    cpu dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .start     (start),
        .i_datain  (i_datain),
        .d_datain  (d_datain),
        .i_addr    (i_addr),
        .d_addr    (d_addr),
        .d_dataout (d_dataout),
        .d_we      (d_we)
    );

    always #5 clock = ~clock;

    assign i_datain = irom[i_addr];
    assign d_datain = dram[d_addr];

    always @(posedge clock) begin
        if (!reset && enable && d_we && dut.r_state == EXEC) dram[d_addr] <= d_dataout;
    end

    // Store monitor: every committed store is matched against the expected queue.
    always @(negedge clock) begin
        if (!reset && enable && d_we && dut.r_state == EXEC) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_store: unexpected store addr=%h data=%h", d_addr, d_dataout);
            end else begin
                sb_e = exp_q.pop_front();
                if ({d_addr, d_dataout} !== sb_e) begin
                    n_fail++;
                    $display("FAIL sb_store: got addr=%h data=%h expected addr=%h data=%h",
                             d_addr, d_dataout, sb_e[23:16], sb_e[15:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] enc_r(input logic [4:0] op, input logic [2:0] r1,
                                          input logic [3:0] v2, input logic [3:0] v3);
        return {op, r1, v2, v3};
    endfunction

    function automatic logic [15:0] enc_i(input logic [4:0] op, input logic [2:0] r1,
                                          input logic [7:0] imm);
        return {op, r1, imm};
    endfunction

    task automatic emit(input logic [15:0] w, input int nops_after);
        prog.push_back(w);
        repeat (nops_after) prog.push_back(16'h0000);
    endtask

    task automatic load_prog;
        for (int i = 0; i < 256; i++) irom[i] = (i < prog.size()) ? prog[i] : 16'h0000;
        prog.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset;
        reset  = 1'b1;
        enable = 1'b1;
        start  = 1'b0;
        tick(2);
        reset  = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 256; i++) dram[i] = 16'h0000;
    endtask

    task automatic start_prog;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (dut.r_state != IDLE && n < budget) begin
            tick(1);
            n++;
        end
        chk(name, dut.r_state, IDLE);
    endtask

    task automatic build_c;
        emit(enc_i(ADDI, 3'd1, 8'h05), 3);
        emit(enc_r(ADD, 3'd3, 4'd1, 4'd1), 3);
        emit(enc_r(STORE, 3'd3, 4'd0, 4'd2), 3);
        emit(enc_r(LOAD, 3'd4, 4'd0, 4'd3), 3);
        emit(enc_i(LDIH, 3'd5, 8'hAB), 3);
        emit(enc_r(SRA, 3'd6, 4'd5, 4'd4), 3);
        emit(enc_i(HALT, 3'd0, 8'h00), 0);
        load_prog;
        dram[3] = 16'h1234;
        exp_q.push_back({8'h02, 16'h000A});
    endtask

    task automatic check_c(input string tag);
        chk({tag, "_gr1"}, dut.gr[1], 16'h0005);
        chk({tag, "_gr3"}, dut.gr[3], 16'h000A);
        chk({tag, "_gr4"}, dut.gr[4], 16'h1234);
        chk({tag, "_gr5"}, dut.gr[5], 16'hAB00);
        chk({tag, "_gr6"}, dut.gr[6], 16'hFAB0);
        chk({tag, "_flag"}, dut.flag, 3'b100);
        chk({tag, "_ram2"}, dram[2], 16'h000A);
        chk({tag, "_sb_empty"}, exp_q.size(), 0);
    endtask

    // Architectural reference: one instruction at a time, no pipeline.
    task automatic model_op(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs2,
                            input logic [2:0] rs3, input logic [7:0] imm);
        int a, b, s;
        logic [15:0] res;
        logic c;
        c = 1'b0;
        case (op)
            ADDI, SUBI:         begin a = m_gr[rd];  b = imm;       end
            LDIH:               begin a = m_gr[rd];  b = imm * 256; end
            SLL, SLA, SRL, SRA: begin a = m_gr[rs2]; b = imm[3:0];  end
            default:            begin a = m_gr[rs2]; b = m_gr[rs3]; end
        endcase
        case (op)
            ADD, ADDI:     begin s = a + b;        c = (s > 65535); end
            ADDC:          begin s = a + b + m_cf; c = (s > 65535); end
            SUB, SUBI, CMP: begin s = a - b;       c = (s < 0);     end
            SUBC:          begin s = a - b - m_cf; c = (s < 0);     end
            LDIH:          s = a + b;
            AND:           s = a & b;
            OR:            s = a | b;
            XOR:           s = a ^ b;
            SLL, SLA:      s = a << b;
            SRL:           s = a >> b;
            default:       s = ((a >= 32768) ? a - 65536 : a) >>> b;
        endcase
        res = s[15:0];
        if (op != CMP) m_gr[rd] = res;
        m_cf = c;
        m_zf = (res == 16'h0000);
        m_nf = res[15];
    endtask

    task automatic random_round(input int n_ops);
        logic [4:0] ops [15];
        logic [4:0] op;
        logic [2:0] rd, rs2, rs3;
        logic [7:0] imm;
        logic [3:0] k;
        ops = '{ADD, ADDI, ADDC, SUB, SUBI, SUBC, CMP, AND, OR, XOR, SLL, SLA, SRL, SRA, LDIH};
        do_reset;
        for (int i = 0; i < 8; i++) m_gr[i] = 16'h0000;
        {m_cf, m_zf, m_nf} = 3'b000;
        for (int i = 0; i < n_ops; i++) begin
            op  = ops[$urandom_range(0, 14)];
            rd  = 3'($urandom_range(1, 7));
            rs2 = 3'($urandom_range(0, 7));
            rs3 = 3'($urandom_range(0, 7));
            imm = 8'($urandom);
            k   = 4'(i);
            case (op)
                ADDI, SUBI, LDIH:   emit(enc_i(op, rd, imm), 3);
                SLL, SLA, SRL, SRA: emit(enc_r(op, rd, {1'b0, rs2}, imm[3:0]), 3);
                default:            emit(enc_r(op, rd, {1'b0, rs2}, {1'b0, rs3}), 3);
            endcase
            model_op(op, rd, rs2, rs3, imm);
            emit(enc_r(STORE, rd, 4'd0, k), 0);
            exp_q.push_back({4'h0, k, m_gr[rd]});
        end
        emit(enc_i(HALT, 3'd0, 8'h00), 0);
        load_prog;
        start_prog;
        wait_idle("rnd_idle", 2000);
        for (int i = 0; i < 8; i++) chk($sformatf("rnd_gr%0d", i), dut.gr[i], m_gr[i]);
        chk("rnd_flag", dut.flag, {m_nf, m_zf, m_cf});
        chk("rnd_sb_empty", exp_q.size(), 0);
    endtask

    logic [7:0]  s_pc;
    logic [15:0] s_id, s_ex, s_gr1, s_gr3;
    logic [2:0]  s_flag;

    initial begin
        // Reset state
        do_reset;
        chk("rst_iaddr", i_addr, 8'h00);
        chk("rst_dwe", d_we, 1'b0);
        chk("rst_daddr", d_addr, 8'h00);
        chk("rst_dout", d_dataout, 16'h0000);
        chk("rst_state", dut.r_state, IDLE);
        chk("rst_flag", dut.flag, 3'b000);

        // BN not taken: nf cleared by preceding ADD
        emit(enc_i(LDIH, 3'd1, 8'hF0), 3);
        emit(enc_i(ADDI, 3'd1, 8'h12), 3);
        emit(enc_r(ADD, 3'd7, 4'd0, 4'd0), 3);
        emit(enc_i(BN, 3'd1, 8'h00), 3);
        emit(enc_i(HALT, 3'd0, 8'h00), 0);
        load_prog;
        start_prog;
        chk("a_state_exec", dut.r_state, EXEC);
        wait_idle("a_idle", 500);
        chk("a_pc", i_addr, 8'd17);
        chk("a_gr1", dut.gr[1], 16'hF012);
        chk("a_flag", dut.flag, 3'b010);

        // BN taken to 0x12; slot 13 is a LOAD delay slot
        do_reset;
        dram[3] = 16'h1234;
        emit(enc_i(LDIH, 3'd1, 8'hF0), 3);
        emit(enc_i(ADDI, 3'd1, 8'h12), 3);
        emit(enc_i(SUBI, 3'd2, 8'h01), 3);
        emit(enc_i(BN, 3'd1, 8'h00), 0);
        emit(enc_r(LOAD, 3'd4, 4'd0, 4'd3), 2);
        emit(enc_i(ADDI, 3'd3, 8'h77), 0);
        emit(enc_i(HALT, 3'd0, 8'h00), 0);
        emit(enc_i(HALT, 3'd0, 8'h00), 0);
        load_prog;
        start_prog;
        wait_idle("b_idle", 500);
        chk("b_pc", i_addr, 8'd19);
        chk("b_gr2", dut.gr[2], 16'hFFFF);
        chk("b_gr3", dut.gr[3], 16'h0000);
        chk("b_flag", dut.flag, 3'b101);
`ifdef BRANCH_FLUSH_EN
        chk("b_slot_gr4", dut.gr[4], 16'h0000);
`else
        chk("b_slot_gr4", dut.gr[4], 16'h1234);
`endif

        // Arithmetic, store, load, LDIH, SRA
        do_reset;
        build_c;
        start_prog;
        wait_idle("c_idle", 500);
        check_c("c");

        // enable low mid-program freezes everything
        do_reset;
        build_c;
        start_prog;
        tick(10);
        enable = 1'b0;
        s_pc = i_addr; s_id = dut.r_id_ir; s_ex = dut.r_ex_ir;
        s_gr1 = dut.gr[1]; s_gr3 = dut.gr[3]; s_flag = dut.flag;
        tick(8);
        chk("frz_pc", i_addr, s_pc);
        chk("frz_id", dut.r_id_ir, s_id);
        chk("frz_ex", dut.r_ex_ir, s_ex);
        chk("frz_gr1", dut.gr[1], s_gr1);
        chk("frz_gr3", dut.gr[3], s_gr3);
        chk("frz_flag", dut.flag, s_flag);
        chk("frz_state", dut.r_state, EXEC);
        enable = 1'b1;
        wait_idle("frz_idle", 500);
        check_c("frz");

        // reset mid-run
        do_reset;
        build_c;
        start_prog;
        tick(14);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        exp_q.delete();
        chk("mrst_pc", i_addr, 8'h00);
        chk("mrst_dwe", d_we, 1'b0);
        chk("mrst_state", dut.r_state, IDLE);
        chk("mrst_gr1", dut.gr[1], 16'h0000);
        chk("mrst_gr3", dut.gr[3], 16'h0000);
        chk("mrst_flag", dut.flag, 3'b000);

        random_round(20);
        random_round(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
